// File: rtl/mult_pkg.sv
// Shared constants for the shift-and-add multiplier.
//   state_t    : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   OP_W       : operand width
//   PROD_W     : product width
//   STEPS      : add/shift steps per multiply (one per multiplier bit)
package mult_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 2 * OP_W;
  localparam int STEPS  = 4;
  localparam int CNT_W  = $clog2(STEPS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/RippleCarry4.sv
// 4-bit ripple-carry adder.
//   carryin  : carry into bit 0
//   X, Y     : addends
//   S        : sum
//   carryout : carry out of bit 3
module RippleCarry4 (
  input  logic       carryin,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  output logic [3:0] S,
  output logic       carryout
);

  logic [4:0] c;

  assign c[0] = carryin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign S[i]   = X[i] ^ Y[i] ^ c[i];
    assign c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
  end

  assign carryout = c[4];

endmodule

// File: rtl/shift_add_mult4.sv
// 4x4 unsigned shift-and-add multiplier, one add per clock through a single
// 4-bit ripple-carry adder.
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset
//   start   : request a multiply (sampled only in IDLE)
//   A, B    : multiplicand / multiplier, captured on accepted start
//   busy    : high while the add/shift steps run
//   done    : one-cycle pulse, product valid
//   product : A*B, held until the next result or reset
module shift_add_mult4
  import mult_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  state_t            state;
  logic [OP_W-1:0]   a_reg;
  logic [OP_W-1:0]   hi;   // upper half of the accumulator
  logic [OP_W-1:0]   lo;   // lower half; starts as B, bit 0 is the current multiplier bit
  logic [CNT_W-1:0]  cnt;

  logic [OP_W-1:0]   addend;
  logic [OP_W-1:0]   sum;
  logic              cout;

  // The C bit of the {C,HI,LO} accumulator only holds a value between the
  // add and the shift; after every shift it is 0. It is therefore carried as
  // the adder carry-out wire and shifted straight into HI[3].
  assign addend = lo[0] ? a_reg : '0;

  RippleCarry4 u_add (
    .carryin  (1'b0),
    .X        (hi),
    .Y        (addend),
    .S        (sum),
    .carryout (cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a_reg   <= '0;
      hi      <= '0;
      lo      <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= A;
            hi    <= '0;
            lo    <= B;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // {cout,sum,lo} >> 1
          hi  <= {cout, sum[OP_W-1:1]};
          lo  <= {sum[0], lo[OP_W-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(STEPS - 1)) begin
            product <= {cout, sum, lo[OP_W-1:1]};
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult4.sv
// Directed self-checking bench for shift_add_mult4.
module tb_shift_add_mult4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int checks   = 0;
  int failures = 0;

  shift_add_mult4 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Issue one multiply and measure it. lat = cycles from acceptance to the
  // done cycle (20 means no done seen), busy_cyc = cycles busy was high,
  // done_w = done pulse width, overlap = cycles with busy and done both high.
  task automatic mult_op(input logic [3:0] a, input logic [3:0] b,
                         output logic [7:0] p, output int lat,
                         output int busy_cyc, output int done_w,
                         output int overlap);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; busy_cyc = 0; overlap = 0;
    while (!done && lat < 20) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    if (busy && done) overlap++;
    p = product;
    done_w = 0;
    while (done && done_w < 5) begin
      done_w++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (product !== 8'h00) begin failures++; $display("FAIL reset_product got=%h exp=00", product); end
    // reset wins over start
    start = 1'b1; A = 4'd2; B = 4'd3;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_priority busy got=%b exp=0", busy); end
    // start accepted in the first IDLE cycle after reset
    reset = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_idle_accept busy got=%b exp=1", busy); end
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    checks++; if (product !== 8'h06 || n >= 20) begin failures++; $display("FAIL first_idle_product got=%h exp=06 wait=%0d", product, n); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] p; int lat, bc, dw, ov;
    mult_op(4'd9, 4'd7, p, lat, bc, dw, ov);
    checks++; if (p !== 8'h3F) begin failures++; $display("FAIL basic_product got=%h exp=3f", p); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    checks++; if (bc !== 4) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
    checks++; if (dw !== 1) begin failures++; $display("FAIL basic_done_width got=%0d exp=1", dw); end
    checks++; if (ov !== 0) begin failures++; $display("FAIL basic_busy_done_overlap got=%0d exp=0", ov); end
  endtask

  task automatic test_corners;
    logic [7:0] p; int lat, bc, dw, ov;
    mult_op(4'd0, 4'd13, p, lat, bc, dw, ov);
    checks++; if (p !== 8'h00) begin failures++; $display("FAIL corner_0x13 got=%h exp=00", p); end
    mult_op(4'd13, 4'd0, p, lat, bc, dw, ov);
    checks++; if (p !== 8'h00) begin failures++; $display("FAIL corner_13x0 got=%h exp=00", p); end
    mult_op(4'd15, 4'd15, p, lat, bc, dw, ov);
    checks++; if (p !== 8'hE1) begin failures++; $display("FAIL corner_15x15 got=%h exp=e1", p); end
  endtask

  // product holds E1 through IDLE and the next RUN, then updates
  task automatic test_hold;
    int n;
    @(negedge clk);
    checks++; if (product !== 8'hE1) begin failures++; $display("FAIL hold_idle got=%h exp=e1", product); end
    A = 4'd1; B = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (product !== 8'hE1) begin failures++; $display("FAIL hold_run got=%h exp=e1", product); end
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    checks++; if (product !== 8'h01) begin failures++; $display("FAIL hold_update got=%h exp=01", product); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int last, ndone, badgap, ov, n;
    A = 4'd3; B = 4'd5; start = 1'b1;
    last = -1; ndone = 0; badgap = 0; ov = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy && done) ov++;
      if (done) begin
        if (last >= 0 && c - last != 6) badgap++;
        if (last < 0 && c != 5) badgap++;
        last = c;
        ndone++;
        checks++; if (product !== 8'h0F) begin failures++; $display("FAIL b2b_product got=%h exp=0f", product); end
      end
    end
    start = 1'b0;
    checks++; if (ndone !== 6) begin failures++; $display("FAIL b2b_done_count got=%0d exp=6", ndone); end
    checks++; if (badgap !== 0) begin failures++; $display("FAIL b2b_spacing bad=%0d exp=0", badgap); end
    checks++; if (ov !== 0) begin failures++; $display("FAIL b2b_overlap got=%0d exp=0", ov); end
    n = 0;
    while ((busy || done) && n < 12) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    int lat, extra;
    @(negedge clk);
    A = 4'd6; B = 4'd11; start = 1'b1;
    @(negedge clk);                         // RUN cycle 1
    start = 1'b0;
    @(negedge clk);                         // RUN cycle 2
    A = 4'd15; B = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    checks++; if (product !== 8'h42) begin failures++; $display("FAIL ignore_product got=%h exp=42", product); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL ignore_restart got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_abort;
    int extra;
    @(negedge clk);
    A = 4'd10; B = 4'd10; start = 1'b1;
    @(negedge clk);                         // RUN 1
    start = 1'b0;
    @(negedge clk);                         // RUN 2
    @(negedge clk);                         // RUN 3
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (product !== 8'h00) begin failures++; $display("FAIL abort_product got=%h exp=00", product); end
    reset = 1'b0;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy || done) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", extra); end
  endtask

  task automatic test_sweep;
    logic [7:0] p, exp; int lat, bc, dw, ov;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        exp = 8'(a * b);
        mult_op(4'(a), 4'(b), p, lat, bc, dw, ov);
        checks++; if (p !== exp) begin failures++; $display("FAIL sweep_%0dx%0d got=%h exp=%h", a, b, p, exp); end
        checks++; if (dw !== 1 || ov !== 0) begin failures++; $display("FAIL sweep_done_%0dx%0d width=%0d overlap=%0d exp=1/0", a, b, dw, ov); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_hold();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
